// File: rtl/aximm_seq_pkg.sv
// Shared types and constants for the AXI-MM CSR test sequencer.
package aximm_seq_pkg;

    // Sequencer states, in the order a test walks through them.
    typedef enum logic [3:0] {
        StIdle,
        StWCfg,
        StWBase,
        StWWgo,
        StPWr,
        StWRgo,
        StPRd,
        StRChk,
        StFin
    } seq_state_e;

    // Test configuration captured on the start cycle.
    typedef struct packed {
        logic [7:0]  length;
        logic [1:0]  burst;
        logic [2:0]  size;
        logic [31:0] addr;
    } seq_cfg_t;

    // Default CSR map of the test top.
    localparam logic [31:0] CFG_ADDR_DEF    = 32'h0000_1000;
    localparam logic [31:0] BASE_ADDR_DEF   = 32'h0000_1004;
    localparam logic [31:0] CTRL_ADDR_DEF   = 32'h0000_1008;
    localparam logic [31:0] STATUS_ADDR_DEF = 32'h0000_100C;

    localparam logic [15:0] POLL_LIMIT_DEF = 16'd4096;
    localparam logic [3:0]  POLL_GAP_DEF   = 4'd8;

    // CTRL go bits (the slave clears them itself).
    localparam logic [31:0] CTRL_WR_GO = 32'h0000_0001;
    localparam logic [31:0] CTRL_RD_GO = 32'h0000_0002;

    // STATUS bit positions.
    localparam int unsigned WR_CMPL = 0;
    localparam int unsigned RD_CMPL = 1;
    localparam int unsigned CHK_LSB = 2;

    // CFG word layout: [7:0] length, [9:8] burst, [12:10] size.
    function automatic logic [31:0] pack_cfg(input logic [7:0] length,
                                             input logic [1:0] burst,
                                             input logic [2:0] size);
        return {19'b0, size, burst, length};
    endfunction

endpackage

// File: rtl/aximm_avmm_req.sv
// Single-request Avalon-MM master engine: presents one request at a time, holds it
// through waitrequest and blocks new requests while a read response is outstanding.
module aximm_avmm_req (
    input  logic        clk_i,
    input  logic        rst_i,
    // request side
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ack_o,
    output logic        rd_pend_o,
    output logic        rdata_valid_o,
    output logic [31:0] rdata_o,
    // Avalon-MM side
    output logic [31:0] avm_address_o,
    output logic [31:0] avm_writedata_o,
    output logic        avm_write_o,
    output logic        avm_read_o,
    input  logic [31:0] avm_readdata_i,
    input  logic        avm_readdatavalid_i,
    input  logic        avm_waitrequest_i
);

    logic pend_q, pend_d;
    logic issue;

    // A request only reaches the bus when no read is in flight; the caller holds
    // req/addr/wdata until ack, which keeps the bus stable across waitrequest.
    assign issue = req_i & ~pend_q;

    // Bus drive, handshake and outstanding-read tracking.
    always_comb begin
        avm_write_o     = issue & we_i;
        avm_read_o      = issue & ~we_i;
        avm_address_o   = issue ? addr_i : 32'h0;
        avm_writedata_o = (issue & we_i) ? wdata_i : 32'h0;
        ack_o           = issue & ~avm_waitrequest_i;
        // Stray responses with nothing outstanding are dropped here.
        rdata_valid_o   = pend_q & avm_readdatavalid_i;
        rdata_o         = avm_readdata_i;
        rd_pend_o       = pend_q;
        pend_d          = pend_q;
        if (rdata_valid_o) begin
            pend_d = 1'b0;
        end
        if (ack_o && !we_i) begin
            pend_d = 1'b1;
        end
    end

    // Outstanding-read flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/aximm_csr_test_seq.sv
// Avalon-MM sequencer that runs one AXI-MM loopback test through the test top's CSRs:
// configure, write-go, poll, read-go, poll, read checker result, report.
module aximm_csr_test_seq
    import aximm_seq_pkg::*;
#(
    parameter logic [31:0] CFG_ADDR    = CFG_ADDR_DEF,
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
    parameter logic [31:0] CTRL_ADDR   = CTRL_ADDR_DEF,
    parameter logic [31:0] STATUS_ADDR = STATUS_ADDR_DEF,
    parameter logic [15:0] POLL_LIMIT  = POLL_LIMIT_DEF,
    parameter logic [3:0]  POLL_GAP    = POLL_GAP_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  i_cfg_length,
    input  logic [1:0]  i_cfg_burst,
    input  logic [2:0]  i_cfg_size,
    input  logic [31:0] i_cfg_addr,
    output logic [31:0] o_address,
    output logic [31:0] o_writedata,
    output logic        o_write,
    output logic        o_read,
    input  logic [31:0] i_readdata,
    input  logic        i_readdatavalid,
    input  logic        i_waitrequest,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_pass,
    output logic        o_timeout
);

    seq_state_e  state_q, state_d;
    seq_cfg_t    cfg_q, cfg_d;
    logic [15:0] poll_q, poll_d;
    logic [3:0]  gap_q, gap_d;
    logic        pass_q, pass_d;
    logic        tout_q, tout_d;

    logic        req, we, ack, rd_pend, rd_valid;
    logic [31:0] addr, wdata, rdata;
    logic        poll_hit;
    logic        unused_rdata;

    assign unused_rdata = ^{rdata[31:4], rd_pend};

    aximm_avmm_req u_req (
        .clk_i               (clk),
        .rst_i               (rst),
        .req_i               (req),
        .we_i                (we),
        .addr_i              (addr),
        .wdata_i             (wdata),
        .ack_o               (ack),
        .rd_pend_o           (rd_pend),
        .rdata_valid_o       (rd_valid),
        .rdata_o             (rdata),
        .avm_address_o       (o_address),
        .avm_writedata_o     (o_writedata),
        .avm_write_o         (o_write),
        .avm_read_o          (o_read),
        .avm_readdata_i      (i_readdata),
        .avm_readdatavalid_i (i_readdatavalid),
        .avm_waitrequest_i   (i_waitrequest)
    );

    // Completion bit watched by whichever poll phase is active.
    assign poll_hit = (state_q == StPWr) ? rdata[WR_CMPL] : rdata[RD_CMPL];

    // Next-state, request and result logic.
    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        poll_d  = poll_q;
        gap_d   = gap_q;
        pass_d  = pass_q;
        tout_d  = tout_q;
        req     = 1'b0;
        we      = 1'b0;
        addr    = 32'h0;
        wdata   = 32'h0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cfg_d   = '{length: i_cfg_length, burst: i_cfg_burst,
                                size: i_cfg_size, addr: i_cfg_addr};
                    pass_d  = 1'b0;
                    tout_d  = 1'b0;
                    state_d = StWCfg;
                end
            end
            StWCfg: begin
                req   = 1'b1;
                we    = 1'b1;
                addr  = CFG_ADDR;
                wdata = pack_cfg(cfg_q.length, cfg_q.burst, cfg_q.size);
                if (ack) state_d = StWBase;
            end
            StWBase: begin
                req   = 1'b1;
                we    = 1'b1;
                addr  = BASE_ADDR;
                wdata = cfg_q.addr;
                if (ack) state_d = StWWgo;
            end
            StWWgo, StWRgo: begin
                req   = 1'b1;
                we    = 1'b1;
                addr  = CTRL_ADDR;
                wdata = (state_q == StWWgo) ? CTRL_WR_GO : CTRL_RD_GO;
                if (ack) begin
                    state_d = (state_q == StWWgo) ? StPWr : StPRd;
                    poll_d  = 16'h0;
                    gap_d   = 4'h0;
                end
            end
            StPWr, StPRd: begin
                // The engine masks req while the previous status read is in flight.
                req  = (gap_q == 4'h0);
                addr = STATUS_ADDR;
                if (gap_q != 4'h0) gap_d = gap_q - 4'd1;
                if (ack && poll_q != 16'hFFFF) poll_d = poll_q + 16'd1;
                if (rd_valid) begin
                    if (poll_hit) begin
                        state_d = (state_q == StPWr) ? StWRgo : StRChk;
                        gap_d   = 4'h0;
                    end else if (poll_q >= POLL_LIMIT) begin
                        tout_d  = 1'b1;
                        pass_d  = 1'b0;
                        state_d = StFin;
                    end else begin
                        gap_d = POLL_GAP;
                    end
                end
            end
            StRChk: begin
                req  = 1'b1;
                addr = STATUS_ADDR;
                if (rd_valid) begin
                    pass_d  = (rdata[CHK_LSB +: 2] == 2'b11);
                    state_d = StFin;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cfg_q   <= '0;
            poll_q  <= 16'h0;
            gap_q   <= 4'h0;
            pass_q  <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            poll_q  <= poll_d;
            gap_q   <= gap_d;
            pass_q  <= pass_d;
            tout_q  <= tout_d;
        end
    end

    // Status outputs.
    always_comb begin
        o_busy    = (state_q != StIdle);
        o_done    = (state_q == StFin);
        o_pass    = pass_q;
        o_timeout = tout_q;
    end

endmodule

// File: tb/tb_aximm_csr_test_seq.sv
// Self-checking bench: a CSR slave model answering from a status script, a
// transaction-level model of the expected test, and a per-cycle output monitor.
module tb_aximm_csr_test_seq;

    localparam int LIMIT = 4;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  i_cfg_length;
    logic [1:0]  i_cfg_burst;
    logic [2:0]  i_cfg_size;
    logic [31:0] i_cfg_addr;
    logic [31:0] o_address;
    logic [31:0] o_writedata;
    logic        o_write;
    logic        o_read;
    logic [31:0] i_readdata;
    logic        i_readdatavalid;
    logic        i_waitrequest;
    logic        o_busy;
    logic        o_done;
    logic        o_pass;
    logic        o_timeout;

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          done_cyc = 0;
    int          done_cnt = 0;
    int          stall_cycles = 0;
    bit          mon_en = 1'b0;
    bit          exp_busy = 1'b0;
    bit          exp_pass;
    bit          exp_to;
    txn_t        log_q[$];
    txn_t        exp_q[$];
    logic [31:0] stat_script[$];

    aximm_csr_test_seq #(
        .POLL_LIMIT (16'd4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .i_cfg_length    (i_cfg_length),
        .i_cfg_burst     (i_cfg_burst),
        .i_cfg_size      (i_cfg_size),
        .i_cfg_addr      (i_cfg_addr),
        .o_address       (o_address),
        .o_writedata     (o_writedata),
        .o_write         (o_write),
        .o_read          (o_read),
        .i_readdata      (i_readdata),
        .i_readdatavalid (i_readdatavalid),
        .i_waitrequest   (i_waitrequest),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_pass          (o_pass),
        .o_timeout       (o_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    function automatic logic [31:0] script_at(input int i);
        if (i < stat_script.size()) return stat_script[i];
        return 32'h0;
    endfunction

    // Expected CSR transactions and result for the current script and cfg.
    task automatic build_model(input logic [7:0] len, input logic [1:0] bu,
                               input logic [2:0] sz, input logic [31:0] ad);
        int          idx;
        logic [31:0] v;
        bit          hit;
        bit          to;
        exp_q.delete();
        idx = 0;
        to  = 1'b0;
        exp_q.push_back('{we: 1'b1, addr: 32'h0000_1000, data: {19'b0, sz, bu, len}});
        exp_q.push_back('{we: 1'b1, addr: 32'h0000_1004, data: ad});
        exp_q.push_back('{we: 1'b1, addr: 32'h0000_1008, data: 32'h1});
        for (int ph = 0; ph < 2; ph++) begin
            if (!to) begin
                hit = 1'b0;
                for (int n = 1; n <= LIMIT && !hit; n++) begin
                    v = script_at(idx);
                    idx++;
                    exp_q.push_back('{we: 1'b0, addr: 32'h0000_100C, data: 32'h0});
                    if (v[ph]) hit = 1'b1;
                end
                if (!hit) to = 1'b1;
                else if (ph == 0)
                    exp_q.push_back('{we: 1'b1, addr: 32'h0000_1008, data: 32'h2});
            end
        end
        exp_to   = to;
        exp_pass = 1'b0;
        if (!to) begin
            v = script_at(idx);
            exp_q.push_back('{we: 1'b0, addr: 32'h0000_100C, data: 32'h0});
            exp_pass = (v[3:2] == 2'b11);
        end
    endtask

    // CSR slave: optional waitrequest stretch, one-cycle read latency.
    initial begin : slave
        bit          req;
        bit          rd_due;
        bit          accepted;
        bit          snap_v;
        int          scnt;
        txn_t        snap;
        logic [31:0] rd_val;
        i_waitrequest   = 1'b0;
        i_readdatavalid = 1'b0;
        i_readdata      = 32'h0;
        rd_due = 1'b0;
        snap_v = 1'b0;
        scnt   = 0;
        rd_val = 32'h0;
        forever begin
            @(negedge clk);
            req      = o_write | o_read;
            accepted = 1'b0;
            if (mon_en && snap_v) begin
                chk("stall_hold_req", {63'b0, req}, 64'h1);
                chk("stall_hold_op", {63'b0, o_write}, {63'b0, snap.we});
                chk("stall_hold_addr", {32'b0, o_address}, {32'b0, snap.addr});
                chk("stall_hold_data", {32'b0, o_writedata}, {32'b0, snap.data});
            end
            snap_v = 1'b0;
            if (req && i_waitrequest) begin
                snap   = '{we: o_write, addr: o_address, data: o_writedata};
                snap_v = 1'b1;
                scnt++;
            end
            if (req && !i_waitrequest && !rst) begin
                accepted = 1'b1;
                log_q.push_back('{we: o_write, addr: o_address,
                                  data: (o_write ? o_writedata : 32'h0)});
                if (o_read) begin
                    rd_due = 1'b1;
                    if (stat_script.size() > 0) rd_val = stat_script.pop_front();
                    else rd_val = 32'h0;
                end
            end
            @(posedge clk);
            #1;
            i_readdatavalid = rd_due;
            i_readdata      = rd_due ? rd_val : 32'h0;
            rd_due          = 1'b0;
            if (stall_cycles == 0) begin
                i_waitrequest = 1'b0;
                scnt = 0;
            end else if (accepted) begin
                i_waitrequest = 1'b1;
                scnt = 0;
            end else begin
                i_waitrequest = (scnt < stall_cycles);
            end
        end
    end

    // Per-cycle monitor against the expected busy/idle behaviour.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("rw_exclusive", {63'b0, o_write & o_read}, 64'h0);
                chk("busy", {63'b0, o_busy}, {63'b0, exp_busy});
                if (!exp_busy) begin
                    chk("idle_req", {62'b0, o_write, o_read}, 64'h0);
                    chk("idle_addr", {32'b0, o_address}, 64'h0);
                    chk("idle_wdata", {32'b0, o_writedata}, 64'h0);
                end
                if (o_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    chk("done_txn_count", log_q.size(), exp_q.size());
                end
                if (rst) exp_busy = 1'b0;
                else if (!exp_busy && start) exp_busy = 1'b1;
                else if (exp_busy && o_done) exp_busy = 1'b0;
            end
        end
    end

    task automatic do_start(input logic [7:0] len, input logic [1:0] bu,
                            input logic [2:0] sz, input logic [31:0] ad);
        @(posedge clk);
        #1;
        i_cfg_length = len;
        i_cfg_burst  = bu;
        i_cfg_size   = sz;
        i_cfg_addr   = ad;
        start        = 1'b1;
        start_cyc    = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (o_done) ok = 1'b1;
        end
    endtask

    task automatic check_result(input string nm, input int d0);
        chk({nm, "_done_cnt"}, done_cnt - d0, 1);
        chk({nm, "_txn_count"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s_txn%0d", nm, i), log_q[i], exp_q[i]);
        end
        chk({nm, "_pass"}, {63'b0, o_pass}, {63'b0, exp_pass});
        chk({nm, "_timeout"}, {63'b0, o_timeout}, {63'b0, exp_to});
    endtask

    task automatic run_case(input string nm, input logic [7:0] len, input logic [1:0] bu,
                            input logic [2:0] sz, input logic [31:0] ad, input int stall,
                            input bit chk_lat);
        int d0;
        int lat;
        bit ok;
        build_model(len, bu, sz, ad);
        log_q.delete();
        stall_cycles = stall;
        d0 = done_cnt;
        do_start(len, bu, sz, ad);
        wait_done(2000, ok);
        chk({nm, "_done_seen"}, {63'b0, ok}, 64'h1);
        repeat (3) @(negedge clk);
        check_result(nm, d0);
        if (chk_lat) begin
            lat = done_cyc - start_cyc + 1;
            n_chk++;
            if (lat >= 12 && lat <= 14) n_pass++;
            else $display("FAIL %s_latency: got %0d cycles, expected 12..14", nm, lat);
        end
    endtask

    initial begin : main
        bit ok;
        int d0;
        rst          = 1'b1;
        start        = 1'b0;
        i_cfg_length = 8'h0;
        i_cfg_burst  = 2'h0;
        i_cfg_size   = 3'h0;
        i_cfg_addr   = 32'h0;
        repeat (3) @(negedge clk);

        // Reset state.
        chk("rst_address", {32'b0, o_address}, 64'h0);
        chk("rst_writedata", {32'b0, o_writedata}, 64'h0);
        chk("rst_write", {63'b0, o_write}, 64'h0);
        chk("rst_read", {63'b0, o_read}, 64'h0);
        chk("rst_busy", {63'b0, o_busy}, 64'h0);
        chk("rst_done", {63'b0, o_done}, 64'h0);
        chk("rst_pass", {63'b0, o_pass}, 64'h0);
        chk("rst_timeout", {63'b0, o_timeout}, 64'h0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);

        // Happy path, zero waitrequest.
        stat_script = '{32'h1, 32'h2, 32'hE};
        run_case("happy", 8'h0F, 2'b01, 3'b011, 32'h100, 0, 1'b1);
        chk("happy_cfg_word", {32'b0, log_q[0].data}, 64'h0000_0D0F);
        chk("happy_cfg_addr", {32'b0, log_q[0].addr}, 64'h0000_1000);
        chk("happy_base_word", {32'b0, log_q[1].data}, 64'h100);
        chk("happy_wgo_word", {32'b0, log_q[2].data}, 64'h1);
        chk("happy_rgo_word", {32'b0, log_q[4].data}, 64'h2);
        chk("happy_pass_lit", {63'b0, o_pass}, 64'h1);

        // Checker reports 01.
        stat_script = '{32'h1, 32'h2, 32'h7};
        run_case("fail", 8'h0F, 2'b01, 3'b011, 32'h100, 0, 1'b0);
        chk("fail_pass_lit", {63'b0, o_pass}, 64'h0);

        // Five-cycle waitrequest on every request.
        stat_script = '{32'h1, 32'h2, 32'hE};
        run_case("stall", 8'h0F, 2'b01, 3'b011, 32'h100, 5, 1'b0);
        stall_cycles = 0;

        // Status never completes.
        stat_script.delete();
        run_case("tmo", 8'h3C, 2'b10, 3'b010, 32'hABC0, 0, 1'b0);
        chk("tmo_txn_lit", log_q.size(), 7);
        chk("tmo_timeout_lit", {63'b0, o_timeout}, 64'h1);

        // Reset with a status read outstanding.
        stat_script = '{32'h0, 32'h0, 32'h0};
        build_model(8'h01, 2'b01, 3'b000, 32'h40);
        log_q.delete();
        d0 = done_cnt;
        do_start(8'h01, 2'b01, 3'b000, 32'h40);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (o_read && !i_waitrequest) ok = 1'b1;
        end
        chk("mrst_read_seen", {63'b0, ok}, 64'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mrst_read", {63'b0, o_read}, 64'h0);
        chk("mrst_busy", {63'b0, o_busy}, 64'h0);
        #1;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("mrst_no_done", done_cnt - d0, 0);

        // Clean test after the abort.
        stat_script = '{32'h1, 32'h2, 32'hE};
        run_case("post_rst", 8'h0F, 2'b01, 3'b011, 32'h100, 0, 1'b0);

        // start pulse during the read poll phase is ignored.
        stat_script = '{32'h1, 32'h0, 32'h0, 32'h2, 32'hE};
        build_model(8'h22, 2'b00, 3'b001, 32'h2000);
        log_q.delete();
        d0 = done_cnt;
        do_start(8'h22, 2'b00, 3'b001, 32'h2000);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (log_q.size() >= 5) ok = 1'b1;
        end
        chk("busy_start_reach_prd", {63'b0, ok}, 64'h1);
        @(posedge clk);
        #1;
        i_cfg_length = 8'hAA;
        i_cfg_burst  = 2'b11;
        i_cfg_size   = 3'b111;
        i_cfg_addr   = 32'hDEAD_0000;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(200, ok);
        chk("busy_start_done_seen", {63'b0, ok}, 64'h1);
        repeat (30) @(negedge clk);
        check_result("busy_start", d0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
